// File: rtl/conv_sched_pkg.sv
// Shared types and width helpers for the conv group-pass scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // At most two kernel pairs may be in flight; this also sizes the result FIFO.
  localparam int unsigned CREDIT_DEPTH = 2;
  localparam int unsigned CREDIT_W     = $clog2(CREDIT_DEPTH + 1);

  function automatic int unsigned dp_width(input int unsigned accum_width,
                                           input int unsigned num_channels);
    return accum_width + $clog2(num_channels);
  endfunction

  function automatic int unsigned res_width(input int unsigned dp_w,
                                            input int unsigned max_groups);
    return dp_w + $clog2(max_groups);
  endfunction

endpackage

// File: rtl/conv_sched_res_fifo.sv
// Two-entry shift FIFO; entry 0 is the registered head driven straight to the result port.
module conv_sched_res_fifo #(
  parameter int unsigned DATA_W = 84
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  logic              tail_valid;
  logic [DATA_W-1:0] tail_data;

  // Caller only pops a valid head and never pushes into a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (tail_valid) begin
            head_data <= tail_data;
            tail_data <= push_data;
          end else begin
            head_data <= push_data;
          end
        end
        2'b01: begin
          head_data  <= tail_data;
          head_valid <= tail_valid;
          tail_valid <= 1'b0;
        end
        2'b10: begin
          if (!head_valid) begin
            head_data  <= push_data;
            head_valid <= 1'b1;
          end else begin
            tail_data  <= push_data;
            tail_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/conv_group_pass_scheduler.sv
// Issues channel-group passes per kernel pair, accumulates datapath sums, emits one result per pair.
// Optional build macro CONV_SCHED_PERF_EN enables the credit-stall cycle counter on o_stall_cnt.
module conv_group_pass_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned ACCUM_WIDTH  = 32,
  parameter int unsigned MAX_GROUPS   = 16,
  parameter int unsigned MAX_PAIRS    = 64,
  localparam int unsigned DP_W   = dp_width(ACCUM_WIDTH, NUM_CHANNELS),
  localparam int unsigned RES_W  = res_width(DP_W, MAX_GROUPS),
  localparam int unsigned GRP_W  = $clog2(MAX_GROUPS),
  localparam int unsigned PAIR_W = $clog2(MAX_PAIRS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [GRP_W:0]          i_num_groups,
  input  logic [PAIR_W:0]         i_num_pairs,
  output logic                    o_rd_en,
  output logic [GRP_W-1:0]        o_rd_grp,
  output logic [PAIR_W-1:0]       o_rd_pair,
  output logic                    o_dp_valid,
  input  logic                    i_dp_valid,
  input  logic signed [DP_W-1:0]  i_dp_sum_a,
  input  logic signed [DP_W-1:0]  i_dp_sum_b,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic signed [RES_W-1:0] o_res_a,
  output logic signed [RES_W-1:0] o_res_b,
  output logic [PAIR_W-1:0]       o_res_pair,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_stall_cnt
);

  localparam int unsigned NG_W      = GRP_W + 1;
  localparam int unsigned NP_W      = PAIR_W + 1;
  localparam int unsigned PEND_W    = $clog2(MAX_GROUPS * MAX_PAIRS) + 1;
  localparam int unsigned PAYLOAD_W = 2 * RES_W + PAIR_W;

  state_t                    state;
  logic [GRP_W-1:0]          last_grp, iss_grp, ret_grp;
  logic [PAIR_W-1:0]         last_pair, iss_pair, ret_pair;
  logic [CREDIT_W-1:0]       credits;
  logic [PEND_W-1:0]         pending;
  logic signed [RES_W-1:0]   acc_a, acc_b;
  logic [PAYLOAD_W-1:0]      head_data;

  logic                      res_pop_c, dp_ret_c, can_issue_c, consume_c, push_c;
  logic [NG_W-1:0]           num_groups_c;
  logic [NP_W-1:0]           num_pairs_c;
  logic signed [RES_W-1:0]   sum_a_c, sum_b_c;

  // Handshake, credit and accumulation terms for the current cycle.
  always_comb begin
    res_pop_c    = o_res_valid & i_res_ready;
    dp_ret_c     = i_dp_valid & (state != ST_IDLE);
    can_issue_c  = (state == ST_ISSUE) && ((iss_grp != '0) || (credits != '0));
    consume_c    = can_issue_c && (iss_grp == '0);
    push_c       = dp_ret_c && (ret_grp == last_grp);
    num_groups_c = (i_num_groups == '0) ? NG_W'(1) : i_num_groups;
    num_pairs_c  = (i_num_pairs == '0) ? NP_W'(1) : i_num_pairs;
    sum_a_c      = {{(RES_W-DP_W){i_dp_sum_a[DP_W-1]}}, i_dp_sum_a};
    sum_b_c      = {{(RES_W-DP_W){i_dp_sum_b[DP_W-1]}}, i_dp_sum_b};
    if (ret_grp != '0) begin
      sum_a_c = acc_a + sum_a_c;
      sum_b_c = acc_b + sum_b_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grp   <= '0;
      last_pair  <= '0;
      iss_grp    <= '0;
      iss_pair   <= '0;
      ret_grp    <= '0;
      ret_pair   <= '0;
      credits    <= CREDIT_W'(CREDIT_DEPTH);
      pending    <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
      o_rd_en    <= 1'b0;
      o_rd_grp   <= '0;
      o_rd_pair  <= '0;
      o_dp_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_rd_en    <= 1'b0;
      o_done     <= 1'b0;
      o_dp_valid <= o_rd_en;
      credits    <= credits - CREDIT_W'(consume_c) + CREDIT_W'(res_pop_c);
      pending    <= pending + PEND_W'(can_issue_c) - PEND_W'(dp_ret_c);

      // Returns arrive in issue order, so a running group index tracks them.
      if (dp_ret_c) begin
        acc_a <= sum_a_c;
        acc_b <= sum_b_c;
        if (ret_grp == last_grp) begin
          ret_grp  <= '0;
          ret_pair <= ret_pair + PAIR_W'(1);
        end else begin
          ret_grp <= ret_grp + GRP_W'(1);
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            last_grp  <= GRP_W'(num_groups_c - NG_W'(1));
            last_pair <= PAIR_W'(num_pairs_c - NP_W'(1));
            iss_grp   <= '0;
            iss_pair  <= '0;
            ret_grp   <= '0;
            ret_pair  <= '0;
            o_busy    <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (can_issue_c) begin
            o_rd_en   <= 1'b1;
            o_rd_grp  <= iss_grp;
            o_rd_pair <= iss_pair;
            if (iss_grp == last_grp) begin
              iss_grp <= '0;
              if (iss_pair == last_pair) begin
                state <= ST_DRAIN;
              end else begin
                iss_pair <= iss_pair + PAIR_W'(1);
              end
            end else begin
              iss_grp <= iss_grp + GRP_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!o_res_valid && (pending == '0)) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  conv_sched_res_fifo #(
    .DATA_W(PAYLOAD_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data ({sum_a_c, sum_b_c, ret_pair}),
    .pop       (res_pop_c),
    .head_valid(o_res_valid),
    .head_data (head_data)
  );

  assign {o_res_a, o_res_b, o_res_pair} = head_data;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] stall_cnt;
  logic        stall_c;

  assign stall_c = (state == ST_ISSUE) && !can_issue_c;

  // Saturating count of ISSUE cycles blocked waiting for a credit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && i_start) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_conv_group_pass_scheduler.sv
// Bench for conv_group_pass_scheduler: behavioural datapath (fixed latency) plus result monitor.
module tb_conv_group_pass_scheduler;

  localparam int unsigned DP_W   = 35;
  localparam int unsigned RES_W  = 39;
  localparam int unsigned GRP_W  = 4;
  localparam int unsigned PAIR_W = 6;
  localparam int          LAT    = 5;

  logic                    clk, rst_n, i_start;
  logic [GRP_W:0]          i_num_groups;
  logic [PAIR_W:0]         i_num_pairs;
  logic                    o_rd_en, o_dp_valid, i_dp_valid;
  logic [GRP_W-1:0]        o_rd_grp;
  logic [PAIR_W-1:0]       o_rd_pair, o_res_pair;
  logic signed [DP_W-1:0]  i_dp_sum_a, i_dp_sum_b;
  logic                    o_res_valid, i_res_ready, o_busy, o_done;
  logic signed [RES_W-1:0] o_res_a, o_res_b;
  logic [31:0]             o_stall_cnt;

  conv_group_pass_scheduler dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_num_groups(i_num_groups), .i_num_pairs(i_num_pairs),
    .o_rd_en(o_rd_en), .o_rd_grp(o_rd_grp), .o_rd_pair(o_rd_pair),
    .o_dp_valid(o_dp_valid), .i_dp_valid(i_dp_valid),
    .i_dp_sum_a(i_dp_sum_a), .i_dp_sum_b(i_dp_sum_b),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_a(o_res_a), .o_res_b(o_res_b), .o_res_pair(o_res_pair),
    .o_busy(o_busy), .o_done(o_done), .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [DP_W-1:0]  tab_a [0:63][0:15];
  logic signed [DP_W-1:0]  tab_b [0:63][0:15];
  logic                    pv [LAT];
  logic signed [DP_W-1:0]  pa [LAT];
  logic signed [DP_W-1:0]  pb [LAT];
  logic                    inject;
  int                      n_res, rd_cnt, done_cnt;
  logic signed [RES_W-1:0] got_a [0:511];
  logic signed [RES_W-1:0] got_b [0:511];
  logic [PAIR_W-1:0]       got_p [0:511];
  int                      n_chk, n_pass;

  initial begin
    n_res = 0; rd_cnt = 0; done_cnt = 0;
    i_dp_valid = 1'b0; i_dp_sum_a = '0; i_dp_sum_b = '0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
  end

  // Datapath model fed by read strobes, plus monitor of accepted results.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; pb[i] = pb[i-1]; end
      pv[0] = o_rd_en;
      pa[0] = tab_a[o_rd_pair][o_rd_grp];
      pb[0] = tab_b[o_rd_pair][o_rd_grp];
      if (o_rd_en) rd_cnt++;
      if (o_done) done_cnt++;
      if (o_res_valid && i_res_ready && n_res < 512) begin
        got_a[n_res] = o_res_a; got_b[n_res] = o_res_b; got_p[n_res] = o_res_pair;
        n_res++;
      end
    end
    i_dp_valid = pv[LAT-1] | inject;
    i_dp_sum_a = pa[LAT-1];
    i_dp_sum_b = pb[LAT-1];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic start_run(input int g, input int p);
    @(posedge clk); #1;
    i_num_groups = (GRP_W+1)'(g);
    i_num_pairs  = (PAIR_W+1)'(p);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 3000 && o_busy; c++) begin
      @(posedge clk); #1;
    end
    chk({name, "_idle"}, o_busy, 0);
    @(negedge clk); #1;
  endtask

  task automatic fill_default();
    for (int p = 0; p < 64; p++)
      for (int g = 0; g < 16; g++) begin
        tab_a[p][g] = DP_W'(72);
        tab_b[p][g] = DP_W'(144);
      end
  endtask

  typedef struct {
    int g; int p; longint exp_a; longint exp_b; int exp_rd; int exp_n;
  } vec_t;

  vec_t vecs [5];
  int   b_res, b_rd, b_done;

  initial begin
    vecs[0] = '{g: 4,  p: 1, exp_a: 288,  exp_b: 576,  exp_rd: 4,  exp_n: 1};
    vecs[1] = '{g: 1,  p: 3, exp_a: 72,   exp_b: 144,  exp_rd: 3,  exp_n: 3};
    vecs[2] = '{g: 0,  p: 1, exp_a: 72,   exp_b: 144,  exp_rd: 1,  exp_n: 1};
    vecs[3] = '{g: 16, p: 2, exp_a: 1152, exp_b: 2304, exp_rd: 32, exp_n: 2};
    vecs[4] = '{g: 3,  p: 0, exp_a: 216,  exp_b: 432,  exp_rd: 3,  exp_n: 1};
    n_chk = 0; n_pass = 0;
    fill_default();
    inject = 1'b0; i_start = 1'b0; i_num_groups = '0; i_num_pairs = '0;
    i_res_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_dp_valid", o_dp_valid, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_res_a", o_res_a, 0);
    chk("rst_stall", o_stall_cnt, 0);
    rst_n = 1'b1;

    // Stray datapath valid while idle must not produce a result.
    i_res_ready = 1'b0;
    @(posedge clk); #1; inject = 1'b1;
    @(posedge clk); #1; inject = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_dp_res_valid", o_res_valid, 0);
    chk("idle_dp_busy", o_busy, 0);
    i_res_ready = 1'b1;

    for (int v = 0; v < 5; v++) begin
      b_res = n_res; b_rd = rd_cnt; b_done = done_cnt;
      start_run(vecs[v].g, vecs[v].p);
      wait_idle($sformatf("v%0d", v));
      chk($sformatf("v%0d_nres", v), n_res - b_res, vecs[v].exp_n);
      chk($sformatf("v%0d_rd", v), rd_cnt - b_rd, vecs[v].exp_rd);
      chk($sformatf("v%0d_done", v), done_cnt - b_done, 1);
      for (int k = 0; k < vecs[v].exp_n; k++) begin
        chk($sformatf("v%0d_pair%0d", v, k), got_p[b_res+k], k);
        chk($sformatf("v%0d_a%0d", v, k), got_a[b_res+k], vecs[v].exp_a);
        chk($sformatf("v%0d_b%0d", v, k), got_b[b_res+k], vecs[v].exp_b);
      end
    end

    // Back-pressure: two pairs queue, issue stalls, then all five drain in order.
    i_res_ready = 1'b0;
    b_res = n_res; b_rd = rd_cnt; b_done = done_cnt;
    start_run(2, 5);
    repeat (80) @(posedge clk);
    #1;
    chk("bp_res_valid", o_res_valid, 1);
    chk("bp_head_pair", o_res_pair, 0);
    chk("bp_head_a", o_res_a, 144);
    chk("bp_rd_stalled", rd_cnt - b_rd, 4);
    chk("bp_busy", o_busy, 1);
    chk("bp_none_taken", n_res - b_res, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_hold_b", o_res_b, 288);
    chk("bp_hold_pair", o_res_pair, 0);
`ifdef CONV_SCHED_PERF_EN
    chk("bp_stall_nonzero", o_stall_cnt != 0, 1);
`else
    chk("bp_stall_zero", o_stall_cnt, 0);
`endif
    i_res_ready = 1'b1;
    wait_idle("bp");
    chk("bp_nres", n_res - b_res, 5);
    chk("bp_done", done_cnt - b_done, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_pair%0d", k), got_p[b_res+k], k);
      chk($sformatf("bp_a%0d", k), got_a[b_res+k], 144);
      chk($sformatf("bp_b%0d", k), got_b[b_res+k], 288);
    end

    // Wide signed sums over 16 groups: no wrap at the 35-bit datapath width.
    begin
      longint ea, eb;
      for (int g = 0; g < 16; g++) begin
        tab_a[0][g] = DP_W'(64'h3_FFFF_FFFF);
        tab_b[0][g] = DP_W'(64'h4_0000_0000);
        tab_a[1][g] = DP_W'({$urandom, $urandom});
        tab_b[1][g] = DP_W'({$urandom, $urandom});
      end
      ea = 0; eb = 0;
      for (int g = 0; g < 16; g++) begin
        ea += longint'(tab_a[1][g]);
        eb += longint'(tab_b[1][g]);
      end
      b_res = n_res;
      start_run(16, 2);
      wait_idle("wide");
      chk("wide_nres", n_res - b_res, 2);
      chk("wide_max_a", got_a[b_res], 64'sd274877906928);
      chk("wide_min_b", got_b[b_res], -64'sd274877906944);
      chk("wide_rand_a", got_a[b_res+1], ea);
      chk("wide_rand_b", got_b[b_res+1], eb);
      fill_default();
    end

    // Start while busy is ignored.
    b_res = n_res; b_rd = rd_cnt;
    start_run(2, 2);
    repeat (2) @(posedge clk);
    start_run(0, 1);
    wait_idle("busy_start");
    chk("busy_start_nres", n_res - b_res, 2);
    chk("busy_start_rd", rd_cnt - b_rd, 4);
    chk("busy_start_a", got_a[b_res+1], 144);

    // Reset in the middle of issuing pair 2, then a clean restart.
    begin
      bit found;
      found = 1'b0;
      start_run(2, 6);
      for (int c = 0; c < 300 && !found; c++) begin
        @(posedge clk); #1;
        if (o_rd_en && o_rd_pair == 2) found = 1'b1;
      end
      chk("mid_reach_pair2", found, 1);
      b_done = done_cnt;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_rd_en", o_rd_en, 0);
      chk("mid_rst_dp_valid", o_dp_valid, 0);
      chk("mid_rst_res_valid", o_res_valid, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_rd_pair", o_rd_pair, 0);
      chk("mid_rst_res_a", o_res_a, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("mid_no_done", done_cnt - b_done, 0);
      chk("mid_idle", o_busy, 0);
      b_res = n_res; b_done = done_cnt;
      start_run(1, 2);
      wait_idle("restart");
      chk("restart_nres", n_res - b_res, 2);
      chk("restart_done", done_cnt - b_done, 1);
      chk("restart_pair1", got_p[b_res+1], 1);
      chk("restart_a0", got_a[b_res], 72);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
